// File: rtl/tx_control_module_pkg.sv
// Shared UART definitions: transmitter FSM states, parity codes (common with the
// receive path) and the baud divider / parity helper functions.
package tx_control_module_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4,
    TX_DONE   = 3'd5
  } tx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Clocks per bit; integer division truncates, as the receive path assumes.
  function automatic int bps_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    case (mode)
      PARITY_EVEN: return ^data;
      PARITY_ODD:  return ~^data;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tx_control_module_bps.sv
// Baud-period timer: free-runs while a frame is in flight and flags the last
// clock of every bit period; held at zero otherwise.
module tx_bps_module #(
  parameter int BPS_DIV = 434
) (
  input  logic CLK,
  input  logic RST,
  input  logic count_en,
  output logic BPS_CLK
);

  localparam int TW = (BPS_DIV > 1) ? $clog2(BPS_DIV) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(BPS_DIV - 1);

  logic [TW-1:0] timer_r;

  // Bit-period counter, wraps on the last tick so the next bit starts at zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      timer_r <= '0;
    end else if (!count_en) begin
      timer_r <= '0;
    end else if (timer_r == LAST_TICK) begin
      timer_r <= '0;
    end else begin
      timer_r <= timer_r + TW'(1);
    end
  end

  assign BPS_CLK = count_en && (timer_r == LAST_TICK);

endmodule

// File: rtl/tx_control_module.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1-2 stop
// bits. Outputs are registered; the baud timer runs only while busy.
module tx_control_module
  import tx_control_module_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Tx_En_Sig,
  input  logic       Tx_Start_Sig,
  input  logic [7:0] Tx_Data,
  output logic       Tx_Pin_Out,
  output logic       Tx_Busy_Sig,
  output logic       Tx_Done_Sig
);

  localparam int BPS_DIV = bps_div(CLK_FREQ, BAUD);
  localparam logic HAS_PARITY = (PARITY != PARITY_NONE);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_e  state_r;
  logic [7:0] shift_r;
  logic       parity_r;
  logic [2:0] bit_cnt_r;
  logic       pin_r;
  logic       busy_r;
  logic       done_r;
  logic       bps_clk_s;

  tx_bps_module #(
    .BPS_DIV (BPS_DIV)
  ) u_bps (
    .CLK      (CLK),
    .RST      (RST),
    .count_en (busy_r),
    .BPS_CLK  (bps_clk_s)
  );

  // Frame sequencer; the pin level for each bit is loaded on the edge that enters it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= TX_IDLE;
      shift_r   <= 8'h00;
      parity_r  <= 1'b0;
      bit_cnt_r <= 3'd0;
      pin_r     <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        TX_IDLE: begin
          pin_r  <= 1'b1;
          busy_r <= 1'b0;
          done_r <= 1'b0;
          if (Tx_Start_Sig && Tx_En_Sig) begin
            shift_r   <= Tx_Data;
            parity_r  <= parity_bit(Tx_Data, PARITY);
            bit_cnt_r <= 3'd0;
            pin_r     <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= TX_START;
          end
        end
        TX_START: begin
          if (bps_clk_s) begin
            pin_r     <= shift_r[0];
            shift_r   <= {1'b0, shift_r[7:1]};
            bit_cnt_r <= 3'd0;
            state_r   <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (bps_clk_s) begin
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_r <= 3'd0;
              if (HAS_PARITY) begin
                pin_r   <= parity_r;
                state_r <= TX_PARITY;
              end else begin
                pin_r   <= 1'b1;
                state_r <= TX_STOP;
              end
            end else begin
              pin_r     <= shift_r[0];
              shift_r   <= {1'b0, shift_r[7:1]};
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
        end
        TX_PARITY: begin
          if (bps_clk_s) begin
            pin_r     <= 1'b1;
            bit_cnt_r <= 3'd0;
            state_r   <= TX_STOP;
          end
        end
        // bit_cnt_r is reused here to count stop-bit periods.
        TX_STOP: begin
          if (bps_clk_s) begin
            if (bit_cnt_r == LAST_STOP) begin
              pin_r   <= 1'b1;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= TX_DONE;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
        end
        TX_DONE: begin
          pin_r   <= 1'b1;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= TX_IDLE;
        end
        default: begin
          pin_r   <= 1'b1;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= TX_IDLE;
        end
      endcase
    end
  end

  assign Tx_Pin_Out  = pin_r;
  assign Tx_Busy_Sig = busy_r;
  assign Tx_Done_Sig = done_r;

endmodule

// File: tb/tb_tx_control_module.sv
// Self-checking bench: four transmitter configurations, each frame compared cycle by
// cycle against a bit list built from the framing rules.
module tb_tx_control_module;

  localparam int BPS  = 50_000_000 / 115200;
  localparam int NDUT = 4;
  localparam int PAR_CFG  [NDUT] = '{0, 2, 1, 0};
  localparam int STOP_CFG [NDUT] = '{1, 1, 1, 2};

  logic            clk_s = 1'b0;
  logic            rst_s;
  logic [NDUT-1:0] en_s;
  logic [NDUT-1:0] start_s;
  logic [7:0]      data_s [NDUT];
  logic [NDUT-1:0] pin_s;
  logic [NDUT-1:0] busy_s;
  logic [NDUT-1:0] done_s;

  int vectors     = 0;
  int miscompares = 0;

  always #10 clk_s = ~clk_s;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    tx_control_module #(
      .CLK_FREQ  (50_000_000),
      .BAUD      (115200),
      .PARITY    (PAR_CFG[g]),
      .STOP_BITS (STOP_CFG[g])
    ) u_dut (
      .CLK          (clk_s),
      .RST          (rst_s),
      .Tx_En_Sig    (en_s[g]),
      .Tx_Start_Sig (start_s[g]),
      .Tx_Data      (data_s[g]),
      .Tx_Pin_Out   (pin_s[g]),
      .Tx_Busy_Sig  (busy_s[g]),
      .Tx_Done_Sig  (done_s[g])
    );
  end

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int frame_len(input int idx);
    return 1 + 8 + ((PAR_CFG[idx] != 0) ? 1 : 0) + STOP_CFG[idx];
  endfunction

  // Reference line level for bit position i of a frame carrying byte b.
  function automatic logic exp_bit(input int idx, input logic [7:0] b, input int i);
    int ones = 0;
    for (int j = 0; j < 8; j++) ones += int'(b[j]);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (PAR_CFG[idx] != 0 && i == 9) begin
      if (PAR_CFG[idx] == 2) return 1'(ones % 2);
      return 1'(1 - (ones % 2));
    end
    return 1'b1;
  endfunction

  // One frame on DUT idx. inj_cycle >= 0: extra start (inj_data) mid-frame and
  // enable dropped from then on. rst_cycle >= 0: reset the frame at that cycle.
  task automatic send(input int idx, input logic [7:0] b, input int inj_cycle,
                      input logic [7:0] inj_data, input int rst_cycle);
    int n = frame_len(idx);
    int bad_line = 0;
    int bad_busy = 0;
    int bad_done = 0;
    @(negedge clk_s);
    chk_bit($sformatf("idle_pin%0d", idx), pin_s[idx], 1'b1);
    chk_bit($sformatf("idle_busy%0d", idx), busy_s[idx], 1'b0);
    data_s[idx]  = b;
    start_s[idx] = 1'b1;
    for (int c = 0; c < n * BPS; c++) begin
      @(negedge clk_s);
      start_s[idx] = 1'b0;
      if (c == 0) chk_bit($sformatf("accept_busy%0d", idx), busy_s[idx], 1'b1);
      if (c == rst_cycle) begin
        rst_s = 1'b1;
        @(negedge clk_s);
        rst_s = 1'b0;
        chk_bit("rst_pin", pin_s[idx], 1'b1);
        chk_bit("rst_busy", busy_s[idx], 1'b0);
        chk_bit("rst_done", done_s[idx], 1'b0);
        for (int w = 0; w < 1000; w++) begin
          @(negedge clk_s);
          if (done_s[idx] !== 1'b0 || busy_s[idx] !== 1'b0 || pin_s[idx] !== 1'b1) bad_done++;
        end
        chk_int("rst_quiet", bad_done, 0);
        return;
      end
      if (pin_s[idx] !== exp_bit(idx, b, c / BPS)) bad_line++;
      if (busy_s[idx] !== 1'b1) bad_busy++;
      if (done_s[idx] !== 1'b0) bad_done++;
      if (c % BPS == BPS / 2)
        chk_bit($sformatf("dut%0d_data%02h_bit%0d", idx, b, c / BPS), pin_s[idx], exp_bit(idx, b, c / BPS));
      data_s[idx] = 8'($urandom);
      if (c == inj_cycle) begin
        start_s[idx] = 1'b1;
        data_s[idx]  = inj_data;
      end
      if (inj_cycle >= 0 && c >= inj_cycle) en_s[idx] = 1'b0;
    end
    @(negedge clk_s);
    start_s[idx] = 1'b0;
    chk_int($sformatf("dut%0d_line_cycles", idx), bad_line, 0);
    chk_int($sformatf("dut%0d_busy_cycles", idx), bad_busy, 0);
    chk_int($sformatf("dut%0d_early_done", idx), bad_done, 0);
    chk_bit($sformatf("dut%0d_done", idx), done_s[idx], 1'b1);
    chk_bit($sformatf("dut%0d_done_busy", idx), busy_s[idx], 1'b0);
    chk_bit($sformatf("dut%0d_done_pin", idx), pin_s[idx], 1'b1);
    en_s[idx] = 1'b1;
  endtask

  initial begin
    rst_s   = 1'b1;
    en_s    = '1;
    start_s = '0;
    for (int i = 0; i < NDUT; i++) data_s[i] = 8'h00;
    repeat (3) @(negedge clk_s);
    chk_int("reset_pin", int'(pin_s), 15);
    chk_int("reset_busy", int'(busy_s), 0);
    chk_int("reset_done", int'(done_s), 0);
    rst_s = 1'b0;

    // No parity, one stop bit: 0x55 alternates the line.
    send(0, 8'h55, -1, 8'h00, -1);
    // Even / odd parity of 0x07.
    send(1, 8'h07, -1, 8'h00, -1);
    send(2, 8'h07, -1, 8'h00, -1);
    // Two stop bits.
    send(3, 8'hA3, -1, 8'h00, -1);
    // Mid-frame start with 0xFF plus enable drop: frame of 0x00 must complete untouched.
    send(0, 8'h00, 100, 8'hFF, -1);

    // Start with enable low is refused.
    @(negedge clk_s);
    en_s[0]    = 1'b0;
    data_s[0]  = 8'hAA;
    start_s[0] = 1'b1;
    @(negedge clk_s);
    start_s[0] = 1'b0;
    chk_bit("en_low_busy", busy_s[0], 1'b0);
    chk_bit("en_low_pin", pin_s[0], 1'b1);
    @(negedge clk_s);
    chk_bit("en_low_pin2", pin_s[0], 1'b1);
    en_s[0] = 1'b1;

    // Reset in data bit 4 of 0x3C, then a clean frame.
    send(0, 8'h3C, -1, 8'h00, 5 * BPS + 100);
    send(0, 8'h5A, -1, 8'h00, -1);

    // Back-to-back: a start during DONE is ignored, the one in the IDLE cycle is taken.
    send(0, 8'h12, -1, 8'h00, -1);
    start_s[0] = 1'b1;
    data_s[0]  = 8'hEE;
    send(0, 8'h34, -1, 8'h00, -1);

    // Random bytes on every configuration.
    for (int i = 0; i < NDUT; i++) send(i, 8'($urandom), -1, 8'h00, -1);

    repeat (3) @(negedge clk_s);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
